alu_ctrl_seq: RTL and testbench

Parametrised, registered successor to the EX-stage ALU control decoder. Decodes {funct7,funct3} and ALUOp into a CTRL_W-bit ALU control code and adds OR/SRL/SRA/SLT and DIV/REM. Sequences multi-cycle MUL/DIV/REM operations with a busy/done handshake that drives the hazard unit's stall. Sits between the ID/EX pipeline register and the ALU.

---
 rtl/alu_ctrl_seq_pkg.sv | 76 +++++++
 rtl/alu_ctrl_decode.sv | 76 +++++++
 rtl/alu_ctrl_seq.sv | 118 +++++++++++
 tb/tb_alu_ctrl_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
// alu_ctrl_seq_pkg: shared constants for the EX-stage ALU control path.
//   - ALUOp encodings from the main decoder
//   - {funct7,funct3} and funct3 codes recognised by the decoder
//   - ALU control codes. New codes extend the original set in place so
//     the existing ALU keeps working unchanged.
//   - sequencer FSM states, decoder result struct, is_multicycle helper
package alu_ctrl_seq_pkg;

   typedef enum logic [1:0] {
      ALUOP_MEM = 2'b00,   // lw/sw address add
      ALUOP_BEQ = 2'b01,   // branch compare
      ALUOP_R   = 2'b10,
      ALUOP_I   = 2'b11
   } alu_op_t;

   // R-type {funct7,funct3}
   localparam logic [9:0] F_AND = 10'b0000000_111;
   localparam logic [9:0] F_OR  = 10'b0000000_110;
   localparam logic [9:0] F_XOR = 10'b0000000_100;
   localparam logic [9:0] F_SLL = 10'b0000000_001;
   localparam logic [9:0] F_SRL = 10'b0000000_101;
   localparam logic [9:0] F_SRA = 10'b0100000_101;
   localparam logic [9:0] F_SLT = 10'b0000000_010;
   localparam logic [9:0] F_ADD = 10'b0000000_000;
   localparam logic [9:0] F_SUB = 10'b0100000_000;
   localparam logic [9:0] F_MUL = 10'b0000001_000;
   localparam logic [9:0] F_DIV = 10'b0000001_100;
   localparam logic [9:0] F_REM = 10'b0000001_110;

   // I-type funct3
   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SLTI = 3'b010;
   localparam logic [2:0] F3_XORI = 3'b100;
   localparam logic [2:0] F3_SRXI = 3'b101;
   localparam logic [2:0] F3_ORI  = 3'b110;
   localparam logic [2:0] F3_ANDI = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SLL = 4'b0100,
      ALU_SRL = 4'b0101,
      ALU_SUB = 4'b0110,
      ALU_SRA = 4'b0111,
      ALU_SLT = 4'b1000,
      ALU_MUL = 4'b1001,
      ALU_DIV = 4'b1010,
      ALU_REM = 4'b1011
   } alu_code_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   typedef struct packed {
      alu_code_t ctrl;
      logic      illegal;
      logic      is_mul;
      logic      is_div;   // DIV or REM
   } dec_t;

   // An op only needs the sequencer when its unit takes more than one cycle.
   function automatic logic is_multicycle(input dec_t d, input int mul_lat,
                                          input int div_lat);
      return (d.is_mul && (mul_lat > 1)) || (d.is_div && (div_lat > 1));
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: pure combinational ALU control decoder.
//   alu_op  in  2   ALUOp from the main decoder
//   funct   in  10  {funct7,funct3}
//   dec     out     {ctrl, illegal, is_mul, is_div}
// Undecodable codes fall back to ADD with illegal set.
module alu_ctrl_decode
   import alu_ctrl_seq_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [9:0] funct,
   output dec_t       dec
);

   logic [6:0] f7;
   logic [2:0] f3;

   assign f7 = funct[9:3];
   assign f3 = funct[2:0];

   always_comb begin
      dec.ctrl    = ALU_ADD;
      dec.illegal = 1'b0;
      dec.is_mul  = 1'b0;
      dec.is_div  = 1'b0;
      case (alu_op)
         ALUOP_MEM: dec.ctrl = ALU_ADD;
         ALUOP_BEQ: dec.ctrl = ALU_SUB;
         ALUOP_R: begin
            case (funct)
               F_AND:   dec.ctrl = ALU_AND;
               F_OR:    dec.ctrl = ALU_OR;
               F_XOR:   dec.ctrl = ALU_XOR;
               F_SLL:   dec.ctrl = ALU_SLL;
               F_SRL:   dec.ctrl = ALU_SRL;
               F_SRA:   dec.ctrl = ALU_SRA;
               F_SLT:   dec.ctrl = ALU_SLT;
               F_ADD:   dec.ctrl = ALU_ADD;
               F_SUB:   dec.ctrl = ALU_SUB;
               F_MUL: begin
                  dec.ctrl   = ALU_MUL;
                  dec.is_mul = 1'b1;
               end
               F_DIV: begin
                  dec.ctrl   = ALU_DIV;
                  dec.is_div = 1'b1;
               end
               F_REM: begin
                  dec.ctrl   = ALU_REM;
                  dec.is_div = 1'b1;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         default: begin  // ALUOP_I: funct7 only matters for the shift-right pair
            case (f3)
               F3_ADDI: dec.ctrl = ALU_ADD;
               F3_SLLI: dec.ctrl = ALU_SLL;
               F3_SLTI: dec.ctrl = ALU_SLT;
               F3_XORI: dec.ctrl = ALU_XOR;
               F3_ORI:  dec.ctrl = ALU_OR;
               F3_ANDI: dec.ctrl = ALU_AND;
               F3_SRXI: begin
                  if (f7 == F7_ALT)
                     dec.ctrl = ALU_SRA;
                  else if (f7 == F7_BASE)
                     dec.ctrl = ALU_SRL;
                  else
                     dec.illegal = 1'b1;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with multi-cycle sequencer.
//   clk_i         in   clock, rising edge
//   rst_i         in   async active-low reset
//   valid_i       in   new instruction presented in EX
//   funct_i       in   {funct7,funct3}
//   ALUOp_i       in   00 lw/sw, 01 beq, 10 R-type, 11 I-type
//   flush_i       in   squash current EX op (wins over valid_i)
//   ALUCtrl_o     out  registered ALU control code
//   ctrl_valid_o  out  ALUCtrl_o holds a live op
//   busy_o        out  multi-cycle op in progress (stall upstream)
//   done_o        out  one-cycle pulse, multi-cycle result valid
//   illegal_o     out  last captured op was undecodable
// A multi-cycle op with latency LAT spends LAT-1 cycles in BUSY and one in
// DONE; a new op may be captured during DONE for back-to-back issue.
module alu_ctrl_seq
   import alu_ctrl_seq_pkg::*;
#(
   parameter int CTRL_W  = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [9:0]        funct_i,
   input  logic [1:0]        ALUOp_i,
   input  logic              flush_i,
   output logic [CTRL_W-1:0] ALUCtrl_o,
   output logic              ctrl_valid_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              illegal_o
);

   // Counter is loaded with LAT-2 so that counting down to 0 yields LAT-1
   // busy cycles.
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

   dec_t              dec;
   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              cv_q, cv_d;
   logic              ill_q, ill_d;

   alu_ctrl_decode u_decode (
      .alu_op (ALUOp_i),
      .funct  (funct_i),
      .dec    (dec)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ctrl_q  <= CTRL_W'(ALU_ADD);
         cv_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         cv_q    <= cv_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      cv_d    = cv_q;
      ill_d   = ill_q;
      if (flush_i) begin
         // ALUCtrl_o deliberately held; only the liveness flags drop.
         state_d = ST_IDLE;
         cnt_d   = '0;
         cv_d    = 1'b0;
         ill_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (valid_i) begin
                  ctrl_d = CTRL_W'(dec.ctrl);
                  ill_d  = dec.illegal;
                  cv_d   = 1'b1;
                  if (is_multicycle(dec, MUL_LAT, DIV_LAT)) begin
                     state_d = ST_BUSY;
                     cnt_d   = dec.is_mul ? MUL_LOAD : DIV_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_IDLE;
                  cv_d    = 1'b0;
               end
            end
            ST_BUSY: begin
               // Leaving at 0 means the counter never underflows.
               if (cnt_q == '0)
                  state_d = ST_DONE;
               else
                  cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign ALUCtrl_o    = ctrl_q;
   assign ctrl_valid_o = cv_q;
   assign illegal_o    = ill_q;
   assign busy_o       = (state_q == ST_BUSY);
   assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] aluop = 2'b00;
   logic [9:0] funct = '0;
   // expected decode of the vector currently on the inputs (hand-computed)
   logic [3:0] cur_code = 4'b0010;
   logic       cur_ill = 1'b0;

   logic [3:0] ctrl0, ctrl1;
   logic       cv0, busy0, done0, ill0;
   logic       cv1, busy1, done1, ill1;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   alu_ctrl_seq u_dut0 (
      .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .funct_i(funct),
      .ALUOp_i(aluop), .flush_i(flush), .ALUCtrl_o(ctrl0),
      .ctrl_valid_o(cv0), .busy_o(busy0), .done_o(done0), .illegal_o(ill0)
   );

   alu_ctrl_seq #(.MUL_LAT(1), .DIV_LAT(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .funct_i(funct),
      .ALUOp_i(aluop), .flush_i(flush), .ALUCtrl_o(ctrl1),
      .ctrl_valid_o(cv1), .busy_o(busy1), .done_o(done1), .illegal_o(ill1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Per instance: cycles of stall still owed, done pulse, last captured op.
   int         mul_lat[2] = '{4, 1};
   int         div_lat[2] = '{32, 2};
   int         m_left[2]  = '{0, 0};
   bit         m_done[2]  = '{0, 0};
   bit         m_cv[2]    = '{0, 0};
   bit         m_ill[2]   = '{0, 0};
   logic [3:0] m_ctrl[2]  = '{4'b0010, 4'b0010};

   function automatic int lat_of(input int k, input logic [3:0] code);
      if (code == 4'b1001) return mul_lat[k];
      if (code == 4'b1010 || code == 4'b1011) return div_lat[k];
      return 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_left[k] = 0; m_done[k] = 0; m_cv[k] = 0; m_ill[k] = 0; m_ctrl[k] = 4'b0010;
         end else if (flush) begin
            m_left[k] = 0; m_done[k] = 0; m_cv[k] = 0; m_ill[k] = 0;
         end else if (m_left[k] > 0) begin
            m_left[k] = m_left[k] - 1;
            m_done[k] = (m_left[k] == 0);
         end else begin
            m_done[k] = 0;
            if (valid) begin
               m_ctrl[k] = cur_code;
               m_ill[k]  = cur_ill;
               m_cv[k]   = 1;
               m_left[k] = lat_of(k, cur_code) - 1;
            end else begin
               m_cv[k] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model dut0", {ctrl0, cv0, busy0, done0, ill0},
          {m_ctrl[0], m_cv[0], (m_left[0] > 0), m_done[0], m_ill[0]});
      chk("model dut1", {ctrl1, cv1, busy1, done1, ill1},
          {m_ctrl[1], m_cv[1], (m_left[1] > 0), m_done[1], m_ill[1]});
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [1:0] op, input logic [9:0] f,
                        input logic [3:0] code, input logic il);
      valid = 1'b1; aluop = op; funct = f; cur_code = code; cur_ill = il;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid = 1'b0; flush = 1'b0;
      end
   endtask

   typedef struct {
      logic [1:0] op;
      logic [9:0] f;
      logic [3:0] code;
      logic       il;
   } vec_t;

   vec_t vecs[16] = '{
      '{2'b10, 10'b0000000_111, 4'b0000, 1'b0},  // AND
      '{2'b10, 10'b0000000_110, 4'b0001, 1'b0},  // OR
      '{2'b10, 10'b0000000_100, 4'b0011, 1'b0},  // XOR
      '{2'b10, 10'b0000000_001, 4'b0100, 1'b0},  // SLL
      '{2'b10, 10'b0000000_101, 4'b0101, 1'b0},  // SRL
      '{2'b10, 10'b0100000_101, 4'b0111, 1'b0},  // SRA
      '{2'b10, 10'b0000000_010, 4'b1000, 1'b0},  // SLT
      '{2'b10, 10'b0100000_000, 4'b0110, 1'b0},  // SUB
      '{2'b10, 10'b0000000_000, 4'b0010, 1'b0},  // ADD
      '{2'b10, 10'b0000000_011, 4'b0010, 1'b1},  // undecodable
      '{2'b11, 10'b0100000_101, 4'b0111, 1'b0},  // SRAI
      '{2'b11, 10'b0000000_101, 4'b0101, 1'b0},  // SRLI
      '{2'b11, 10'b1010101_000, 4'b0010, 1'b0},  // ADDI, funct7 ignored
      '{2'b11, 10'b1111111_111, 4'b0000, 1'b0},  // ANDI, funct7 ignored
      '{2'b00, 10'b1011010_010, 4'b0010, 1'b0},  // lw/sw
      '{2'b01, 10'b0110011_110, 4'b0110, 1'b0}   // beq
   };

   localparam logic [9:0] MUL_F = 10'b0000001_000;
   localparam logic [9:0] DIV_F = 10'b0000001_100;
   localparam logic [9:0] REM_F = 10'b0000001_110;
   localparam logic [9:0] SUB_F = 10'b0100000_000;

   initial begin
      // reset values
      @(negedge clk);
      chk("rst ctrl", ctrl0, 4'b0010);
      chk("rst cv/busy/done/ill", {cv0, busy0, done0, ill0}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // decode sweep, back-to-back single-cycle ops
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("sweep ctrl", ctrl0, vecs[i-1].code);
            chk("sweep ill", ill0, vecs[i-1].il);
         end
         drive(vecs[i].op, vecs[i].f, vecs[i].code, vecs[i].il);
      end
      @(negedge clk);
      chk("sweep ctrl last", ctrl0, 4'b0110);
      chk("sweep cv", cv0, 1'b1);
      valid = 1'b0;
      @(negedge clk);
      chk("idle cv drop", cv0, 1'b0);
      chk("idle ctrl hold", ctrl0, 4'b0110);

      // MUL: dut0 stalls 3 cycles then done; dut1 (lat 1) is single-cycle
      drive(2'b10, MUL_F, 4'b1001, 1'b0);
      @(negedge clk);
      chk("mul ctrl0", ctrl0, 4'b1001);
      chk("mul busy0 c1", busy0, 1'b1);
      chk("mul1 ctrl", ctrl1, 4'b1001);
      chk("mul1 busy/done", {busy1, done1}, 2'b00);
      drive(2'b10, SUB_F, 4'b0110, 1'b0);
      @(negedge clk);
      chk("mul busy0 c2", busy0, 1'b1);
      chk("mul sub ignored", ctrl0, 4'b1001);
      @(negedge clk);
      chk("mul busy0 c3", busy0, 1'b1);
      chk("mul no early done", done0, 1'b0);
      @(negedge clk);
      chk("mul done0", {busy0, done0}, 2'b01);
      @(negedge clk);
      chk("sub on done", ctrl0, 4'b0110);
      chk("after done", {busy0, done0}, 2'b00);
      idle(2);

      // REM completes after 31 busy cycles
      drive(2'b10, REM_F, 4'b1011, 1'b0);
      idle(31);
      chk("rem busy last", {busy0, done0}, 2'b10);
      idle(1);
      chk("rem done", {ctrl0, busy0, done0}, {4'b1011, 2'b01});
      idle(2);

      // DIV flushed on busy cycle 5: no done ever
      drive(2'b10, DIV_F, 4'b1010, 1'b0);
      idle(4);
      @(negedge clk);
      chk("div busy c5", busy0, 1'b1);
      valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush state", {cv0, busy0, done0, ill0}, 4'b0000);
      chk("flush ctrl hold", ctrl0, 4'b1010);
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         chk("flush no done", {busy0, done0}, 2'b00);
      end

      // dut1 back-to-back MUL (lat 1) then DIV (lat 2)
      @(negedge clk);
      drive(2'b10, MUL_F, 4'b1001, 1'b0);
      @(negedge clk);
      chk("b2b mul1", {ctrl1, busy1, done1}, {4'b1001, 2'b00});
      drive(2'b10, DIV_F, 4'b1010, 1'b0);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b div1 busy", {ctrl1, busy1, done1}, {4'b1010, 2'b10});
      @(negedge clk);
      chk("b2b div1 done", {busy1, done1}, 2'b01);
      idle(6);

      // async reset mid-BUSY of DIV
      drive(2'b10, DIV_F, 4'b1010, 1'b0);
      idle(4);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async rst ctrl", ctrl0, 4'b0010);
      chk("async rst flags", {cv0, busy0, done0, ill0}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      idle(35);
      chk("post rst quiet", {busy0, done0}, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
